// File: rtl/fsm_ones_detect.sv
// rtl/fsm_ones_detect.sv - counts qualified ones and pulses flag every N-th one
module fsm_ones_detect #(
  parameter  int N  = 4,
  parameter  int HW = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          data,
  input  logic          consec,
  input  logic          overlap,
  input  logic          clr,
  output logic          flag,
  output logic [CW-1:0] level,
  output logic [HW-1:0] hit_cnt
);

  typedef enum logic {ST_COUNT = 1'b0, ST_HIT = 1'b1} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   level_q, level_d;
  logic [HW-1:0]   hit_cnt_q, hit_cnt_d;

  always_comb begin
    state_d   = ST_COUNT;
    level_d   = level_q;
    hit_cnt_d = hit_cnt_q;
    if (clr) begin
      level_d   = '0;
      hit_cnt_d = '0;
    end else if (en) begin
      if (data) begin
        if (level_q == LAST) begin
          state_d = ST_HIT;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          // overlap keeps the window full so each further one hits again
          if (!overlap) level_d = '0;
        end else begin
          level_d = level_q + 1'b1;
        end
      end else if (consec) begin
        level_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_COUNT;
      level_q   <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign flag    = (state_q == ST_HIT);
  assign level   = level_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_fsm_ones_detect.sv
// tb/tb_fsm_ones_detect.sv - directed and random checks of fsm_ones_detect against a count model
module tb_fsm_ones_detect;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, data = 1'b0, consec = 1'b0, overlap = 1'b0, clr = 1'b0;

  logic       flag_a;
  logic [1:0] level_a;
  logic [7:0] hit_a;
  logic       flag_b;
  logic [0:0] level_b;
  logic [1:0] hit_b;

  int errors = 0;
  int checks = 0;

  int nn[2]   = '{4, 2};
  int hmax[2] = '{255, 3};
  int m_lvl[2];
  int m_flg[2];
  int m_hit[2];

  always #5 clk = ~clk;

  fsm_ones_detect #(.N(4), .HW(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .data(data), .consec(consec),
    .overlap(overlap), .clr(clr), .flag(flag_a), .level(level_a), .hit_cnt(hit_a)
  );

  fsm_ones_detect #(.N(2), .HW(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .data(data), .consec(consec),
    .overlap(overlap), .clr(clr), .flag(flag_b), .level(level_b), .hit_cnt(hit_b)
  );

  function automatic int sat_inc(int v, int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  // Reference: number of qualifying ones seen in the current group.
  function void model_edge(int i);
    if (clr) begin
      m_lvl[i] = 0; m_flg[i] = 0; m_hit[i] = 0;
    end else if (!en) begin
      m_flg[i] = 0;
    end else if (data) begin
      if (m_lvl[i] + 1 >= nn[i]) begin
        m_flg[i] = 1;
        m_hit[i] = sat_inc(m_hit[i], hmax[i]);
        m_lvl[i] = overlap ? nn[i] - 1 : 0;
      end else begin
        m_lvl[i] = m_lvl[i] + 1;
        m_flg[i] = 0;
      end
    end else begin
      m_flg[i] = 0;
      if (consec) m_lvl[i] = 0;
    end
  endfunction

  function void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_flg[i] = 0; m_hit[i] = 0;
    end
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("a.flag",  int'(flag_a),  m_flg[0]);
    check("a.level", int'(level_a), m_lvl[0]);
    check("a.hits",  int'(hit_a),   m_hit[0]);
    check("b.flag",  int'(flag_b),  m_flg[1]);
    check("b.level", int'(level_b), m_lvl[1]);
    check("b.hits",  int'(hit_b),   m_hit[1]);
  endtask

  task automatic step(input logic e, input logic d, input logic c,
                      input logic o, input logic cl);
    en = e; data = d; consec = c; overlap = o; clr = cl;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst = 1'b1;
  endtask

  task automatic run_bits(input string bits, input logic c, input logic o);
    for (int i = 0; i < bits.len(); i++)
      step(1'b1, bits[i] == "1", c, o, 1'b0);
  endtask

  initial begin
    model_reset();
    #2 check_all();
    #5 rst = 1'b1;

    // cumulative, restart: hit on the 6th sample
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_bits("1101011", 1'b0, 1'b0);
    check("tp1.hits", int'(hit_a), 1);

    // consecutive: the zero breaks the first run
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_bits("11101111", 1'b1, 1'b0);
    check("tp2.hits", int'(hit_a), 1);

    // consecutive + overlap: four back-to-back pulses
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_bits("1111111", 1'b1, 1'b1);
    check("tp3.hits", int'(hit_a), 4);
    check("tp3.level", int'(level_a), 3);

    // en gating holds level
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_bits("111", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tp4.level_hold", int'(level_a), 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tp4.flag", int'(flag_a), 1);

    // saturation on the HW=2 instance, then clr colliding with a hit
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_bits("111111111111111111111", 1'b0, 1'b0);
    check("tp5.sat", int'(hit_b), 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("tp5.clr_flag", int'(flag_b), 0);
    check("tp5.clr_hits", int'(hit_b), 0);

    // async reset mid-count, then a clean group
    run_bits("11", 1'b0, 1'b0);
    check("tp6.level2", int'(level_a), 2);
    async_reset_pulse();
    run_bits("1111", 1'b0, 1'b0);
    check("tp6.hits", int'(hit_a), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 79) == 0) async_reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_ones_detect.md
# fsm_ones_detect

Parametrised successor to the 4-ones Moore detector. The block counts `data == 1` samples on a serial bit stream and raises a one-cycle `flag` pulse when the count reaches `N`. The threshold is set at elaboration time. Runtime controls select consecutive-vs-cumulative counting and overlapping-vs-restart behaviour, and a saturating hit counter and a live count level are exposed for status logic. It sits in the serial-input control path, where downstream sequencers consume `flag`.

## Interface
- `N`, 4: number of qualifying ones per hit; legal range 2..256.
- `HW`, 8: width of `hit_cnt`; legal range 1..32.
- `CW` (localparam): `$clog2(N)`; width of `level`.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample qualifier; `data` is ignored when 0.
- `data`  in  1  serial input bit.
- `consec`  in  1  1 = ones must be consecutive (a qualified 0 clears the count); 0 = cumulative (a qualified 0 holds the count).
- `overlap`  in  1  1 = after a hit the count stays at N-1, so every further qualifying 1 hits again; 0 = the count restarts from 0.
- `clr`  in  1  synchronous clear of `level`, `flag` and `hit_cnt`.
- `flag`  out  1  registered one-cycle pulse per hit.
- `level`  out  CW  current count of qualifying ones (0..N-1).
- `hit_cnt`  out  HW  number of hits since reset or `clr`, saturating at 2^HW-1.

## Operation
- Reset (`rst` = 0, asynchronous): `level` = 0, `flag` = 0, `hit_cnt` = 0. Release is synchronous to `clk`.
- States (encoded by `level` plus the `flag` register):
  - COUNT(k), k = 0..N-1: k qualifying ones accumulated.
  - HIT: the `flag` = 1 cycle.
- Per rising edge, in priority order:
  1. `clr` = 1: `level` <= 0, `flag` <= 0, `hit_cnt` <= 0. Inputs `en`, `data`, `consec` and `overlap` are ignored.
  2. `en` = 0: `level` holds, `flag` <= 0, `hit_cnt` holds.
  3. `en` = 1, `data` = 1, `level` < N-1: `level` <= `level` + 1, `flag` <= 0.
  4. `en` = 1, `data` = 1, `level` == N-1: this is a hit.
     - `flag` <= 1.
     - `hit_cnt` <= `hit_cnt` + 1, unless it already equals all-ones.
     - `level` <= 0 if `overlap` = 0; `level` stays N-1 if `overlap` = 1.
  5. `en` = 1, `data` = 0: `flag` <= 0.
     - `consec` = 1: `level` <= 0.
     - `consec` = 0: `level` holds.
- The sample taken in the HIT cycle counts toward the next group. With `overlap` = 0 and `data` = 1 in that cycle, `level` goes to 1, matching the original s4 -> s1 transition.
- `consec` and `overlap` are sampled every edge. Changing them mid-count does not clear `level`; the new value governs the next qualified sample.
- With `overlap` = 1 and `consec` = 0, every qualifying 1 after the first hit is also a hit.
- `level` never exceeds N-1. No arithmetic wraps except the defined restart to 0.
- `hit_cnt` saturates and does not wrap. A hit at saturation still pulses `flag`.

## Timing
- Latency: the Nth qualifying 1 is sampled at edge k. `flag` is high from edge k until edge k+1.
- `flag` is a one-cycle pulse; it is high for consecutive cycles only on back-to-back hits (overlap mode).
- `level` and `hit_cnt` update on the same edge as `flag`.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-count or during HIT: all outputs go to 0 immediately (asynchronously). The first count after release uses the first qualified sample.
- `clr` and a hit in the same cycle: `clr` wins, `flag` = 0 next cycle, `hit_cnt` = 0.
- No handshake: one sample per cycle when `en` = 1, never back-pressured.

## Test plan
- N=4, `consec`=0, `overlap`=0, `en`=1; data 1,1,0,1,0,1,1 -> `flag` high only in the cycle after the 4th one (6th sample); `level` sequence 1,2,2,3,3,0,1; `hit_cnt` = 1.
- N=4, `consec`=1, `overlap`=0; data 1,1,1,0,1,1,1,1 -> no flag after the first three ones (`level` goes to 0 on the 0); flag after the 8th sample; `hit_cnt` = 1.
- N=4, `consec`=1, `overlap`=1; data 1 x7 -> `flag` high in the cycles after samples 4, 5, 6 and 7 (four back-to-back pulses); `hit_cnt` = 4; `level` holds at 3.
- N=4; data 1,1,1 with `en`=1, then 3 cycles with `en`=0 and data=1, then data 1 with `en`=1 -> `level` holds at 3 while `en`=0; a single `flag` follows the en-qualified 4th one.
- HW=2, N=2, `overlap`=0; 10 hits -> `hit_cnt` stops at 3 while `flag` still pulses 10 times. Then assert `clr` in the same cycle as a hit -> next cycle `flag`=0, `hit_cnt`=0, `level`=0.
- Drive `level` to 2 (N=4), then pulse `rst` low asynchronously mid-cycle -> `flag`, `level` and `hit_cnt` read 0 before the next clock edge. After release, 4 ones -> exactly one `flag`.
